// File: rtl/reg64_byte_reader_pkg.sv
// ---------------------------------------------------------------------------
// reg64_byte_reader_pkg
// Shared definitions for the 64-bit register byte reader:
//   state_t            - FSM encoding (IDLE, SEND, DONE)
//   BYTE_W             - width of one byte lane
//   DEFAULT_NUM_BYTES  - default number of byte lanes in the captured word
// ---------------------------------------------------------------------------
package reg64_byte_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int BYTE_W            = 8;
  localparam int DEFAULT_NUM_BYTES = 8;

endpackage

// File: rtl/reg64_lane_mux.sv
// ---------------------------------------------------------------------------
// reg64_lane_mux
// Combinational byte-lane select out of the captured register word.
// Build option: REG64_READER_MSB_FIRST_EN reverses the lane order so that
// index 0 selects the most significant byte.
// Ports:
//   word  in   BYTE_W*NUM_BYTES  captured register word
//   idx   in   IDX_W             lane index (0..NUM_BYTES-1)
//   lane  out  BYTE_W            selected byte
// ---------------------------------------------------------------------------
module reg64_lane_mux
  import reg64_byte_reader_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int IDX_W     = 3
) (
  input  logic [BYTE_W*NUM_BYTES-1:0] word,
  input  logic [IDX_W-1:0]            idx,
  output logic [BYTE_W-1:0]           lane
);

  // Compare-and-select over every lane keeps all part-selects constant,
  // so an out-of-range index simply yields zero.
  always_comb begin
    lane = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (idx == IDX_W'(k)) begin
`ifdef REG64_READER_MSB_FIRST_EN
        lane = word[BYTE_W*(NUM_BYTES-1-k) +: BYTE_W];
`else
        lane = word[BYTE_W*k +: BYTE_W];
`endif
      end
    end
  end

endmodule

// File: rtl/reg64_byte_reader.sv
// ---------------------------------------------------------------------------
// reg64_byte_reader
// Captures a register word on start and streams it out one byte per
// valid/ready transfer, then pulses done for one cycle.
// Build option: REG64_READER_MSB_FIRST_EN (handled in reg64_lane_mux)
// streams the most significant byte first.
// Ports:
//   clk         in   1                 rising-edge clock
//   reset       in   1                 synchronous active-high reset
//   start       in   1                 capture d_in and begin (IDLE only)
//   d_in        in   8*NUM_BYTES       register word to read out
//   byte_ready  in   1                 downstream accepts byte_out
//   byte_out    out  8                 current byte lane
//   byte_valid  out  1                 byte_out is valid
//   byte_idx    out  IDX_W             lane number of byte_out
//   busy        out  1                 high in SEND and DONE
//   done        out  1                 one-cycle pulse after last byte
// ---------------------------------------------------------------------------
module reg64_byte_reader
  import reg64_byte_reader_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int IDX_W     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [BYTE_W*NUM_BYTES-1:0] d_in,
  input  logic                        byte_ready,
  output logic [BYTE_W-1:0]           byte_out,
  output logic                        byte_valid,
  output logic [IDX_W-1:0]            byte_idx,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t                      state;
  state_t                      state_next;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            idx_next;
  logic [BYTE_W*NUM_BYTES-1:0] shadow;
  logic                        capture;
  logic [BYTE_W-1:0]           lane;

  reg64_lane_mux #(
    .NUM_BYTES (NUM_BYTES),
    .IDX_W     (IDX_W)
  ) u_lane_mux (
    .word (shadow),
    .idx  (idx),
    .lane (lane)
  );

  // State, lane index and shadow word; the shadow only loads on capture so
  // later changes on d_in cannot disturb bytes already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (capture) begin
        shadow <= d_in;
      end
    end
  end

  // Next-state and outputs. A transfer only exists in SEND, where valid is
  // high, so byte_ready is naturally ignored in every other state.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    byte_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        if (byte_ready) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte lane is only driven while it is valid, keeping the bus quiet
  // (and zero after reset) otherwise.
  assign byte_out = byte_valid ? lane : '0;
  assign byte_idx = idx;

endmodule

// File: tb/tb_reg64_byte_reader.sv
// ---------------------------------------------------------------------------
// tb_reg64_byte_reader
// Self-checking bench for reg64_byte_reader. Honours
// REG64_READER_MSB_FIRST_EN when computing expected byte order.
// ---------------------------------------------------------------------------
module tb_reg64_byte_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] d_in;
  logic        byte_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [2:0]  byte_idx;
  logic        busy;
  logic        done;

  reg64_byte_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .d_in       (d_in),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [63:0] d;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_byte;
    logic [2:0]  exp_idx;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic [2:0] idx;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  // Expected byte for lane index k of word w, in the configured order.
  function automatic logic [7:0] exp_lane(input logic [63:0] w, input int k);
    int l;
`ifdef REG64_READER_MSB_FIRST_EN
    l = 7 - k;
`else
    l = k;
`endif
    return w[8*l +: 8];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_output(input string name, input logic v, input logic bsy,
                              input logic dn, input logic [7:0] b, input logic [2:0] ix);
    check({name, "_valid"}, byte_valid, v);
    check({name, "_busy"}, busy, bsy);
    check({name, "_done"}, done, dn);
    if (v) begin
      check({name, "_byte"}, byte_out, b);
      check({name, "_idx"}, byte_idx, ix);
    end
  endtask

  // Queue the eight bytes a captured word must produce.
  task automatic push_word(input logic [63:0] w);
    sb_t e;
    for (int k = 0; k < 8; k++) begin
      e.b   = exp_lane(w, k);
      e.idx = 3'(k);
      sb_q.push_back(e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic add_vec(input logic st, input logic [63:0] d, input logic rdy,
                         input logic v, input logic [7:0] b, input logic [2:0] ix,
                         input logic bsy, input logic dn);
    vec_t e;
    e.start = st; e.d = d; e.ready = rdy; e.exp_valid = v;
    e.exp_byte = b; e.exp_idx = ix; e.exp_busy = bsy; e.exp_done = dn;
    vecs.push_back(e);
  endtask

  task automatic apply_stimulus(input string name);
    foreach (vecs[i]) begin
      start      = vecs[i].start;
      d_in       = vecs[i].d;
      byte_ready = vecs[i].ready;
      if (vecs[i].start && !vecs[i].exp_busy) push_word(vecs[i].d);
      @(negedge clk);
      check_output(name, vecs[i].exp_valid, vecs[i].exp_busy, vecs[i].exp_done,
                   vecs[i].exp_byte, vecs[i].exp_idx);
      next_cycle();
    end
    vecs.delete();
    start = 1'b0;
  endtask

  // Scoreboard monitor: every accepted byte must match the head of the queue.
  always @(negedge clk) begin
    sb_t e;
    if (done) done_count++;
    if (!reset && byte_valid && byte_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got byte %0h idx %0d expected no transfer", byte_out, byte_idx);
      end else begin
        e = sb_q.pop_front();
        check("sb_byte", byte_out, e.b);
        check("sb_idx", byte_idx, e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] words [4];
    int k;
    int c;
    int done_before;

    reset = 1'b1; start = 1'b0; d_in = '0; byte_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_byte", byte_out, 8'h00);
    check("rst_idx", byte_idx, 3'd0);
    next_cycle();
    reset = 1'b0;

    // Streaming with ready tied high.
    w = 64'h0807060504030201;
    add_vec(1'b1, w, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      add_vec(1'b0, w, 1'b1, 1'b1, exp_lane(w, i), 3'(i), 1'b1, 1'b0);
    add_vec(1'b0, w, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    add_vec(1'b0, w, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    apply_stimulus("stream");

    // Backpressure with ready pattern 1,0,0 repeating.
    add_vec(1'b1, w, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    k = 0; c = 0;
    while (k < 8) begin
      add_vec(1'b0, w, (c % 3) == 0, 1'b1, exp_lane(w, k), 3'(k), 1'b1, 1'b0);
      if ((c % 3) == 0) k++;
      c++;
    end
    add_vec(1'b0, w, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    add_vec(1'b0, w, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    apply_stimulus("bp");

    // Starts during SEND and DONE are ignored; shadow isolates d_in changes.
    w = {8{8'hAA}};
    start = 1'b1; d_in = w; byte_ready = 1'b1;
    push_word(w);
    next_cycle();
    d_in = {8{8'h55}};
    for (int i = 1; i <= 9; i++) begin
      start = 1'b1;
      @(negedge clk);
      if (i <= 8) check_output("ign", 1'b1, 1'b1, 1'b0, 8'hAA, 3'(i-1));
      else        check_output("ign_done", 1'b0, 1'b1, 1'b1, 8'h00, 3'd0);
      next_cycle();
    end
    start = 1'b0;
    @(negedge clk);
    check_output("ign_idle", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    next_cycle();
    w = {8{8'h55}};
    start = 1'b1; d_in = w;
    push_word(w);
    next_cycle();
    start = 1'b0; d_in = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) check_output("re", 1'b1, 1'b1, 1'b0, 8'h55, 3'(i));
      else       check_output("re_done", 1'b0, 1'b1, 1'b1, 8'h00, 3'd0);
      next_cycle();
    end

    // Reset after three bytes are accepted: no done, everything clears.
    w = 64'h1122334455667788;
    start = 1'b1; d_in = w; byte_ready = 1'b1;
    push_word(w);
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("pre_rst", 1'b1, 1'b1, 1'b0, exp_lane(w, i), 3'(i));
      next_cycle();
    end
    done_before = done_count;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", byte_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_byte", byte_out, 8'h00);
    check("mid_rst_idx", byte_idx, 3'd0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_abandoned", sb_q.size(), 5);
    sb_q.delete();
    repeat (12) next_cycle();
    check("mid_rst_no_done", done_count, done_before);

    // start held high: one word every 10 cycles, d_in recaptured in IDLE.
    for (int i = 0; i < 4; i++) words[i] = {$urandom, $urandom};
    byte_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      start = 1'b1;
      d_in  = words[(cyc + 9) / 10];
      if ((cyc % 10) == 0) push_word(words[cyc / 10]);
      @(negedge clk);
      check("b2b_done", done, (cyc % 10) == 9);
      check("b2b_busy", busy, (cyc % 10) != 0);
      next_cycle();
    end
    start = 1'b0;
    @(negedge clk);
    check_output("b2b_idle", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    next_cycle();

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
